// File: rtl/gcd_controller.sv
// Control FSM for a subtractive GCD datapath: load A, load B, subtract the smaller operand until A==B.
// Define GCD_ITER_LIMIT_EN to add an ERROR state entered once MAX_ITER subtraction cycles are used.
module gcd_controller #(
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic             ldA,
    output logic             ldB,
    output logic             sel1,
    output logic             sel2,
    output logic             sel_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_count,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CALC   = 3'd3,
        DONE   = 3'd4
`ifdef GCD_ITER_LIMIT_EN
        , ERROR = 3'd5
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             limit_hit;

    // Counter saturates at all-ones rather than wrapping.
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign limit_hit = (32'(cnt_q) == MAX_ITER);

`ifndef GCD_ITER_LIMIT_EN
    logic unused_limit_hit;
    assign unused_limit_hit = limit_hit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ldA     = 1'b0;
        ldB     = 1'b0;
        sel1    = 1'b0;
        sel2    = 1'b0;
        sel_in  = 1'b1;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD_A;
            end
            LOAD_A: begin
                ldA     = 1'b1;
                busy    = 1'b1;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                ldB     = 1'b1;
                busy    = 1'b1;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                busy = 1'b1;
                // Priority eq > limit > gt > lt keeps malformed flags deterministic.
                if (eq) begin
                    state_d = DONE;
`ifdef GCD_ITER_LIMIT_EN
                end else if (limit_hit) begin
                    state_d = ERROR;
`endif
                end else if (gt) begin
                    ldA    = 1'b1;
                    sel2   = 1'b1;
                    sel_in = 1'b0;
                    cnt_d  = cnt_inc;
                end else if (lt) begin
                    ldB    = 1'b1;
                    sel1   = 1'b1;
                    sel_in = 1'b0;
                    cnt_d  = cnt_inc;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = LOAD_A;
            end
`ifdef GCD_ITER_LIMIT_EN
            ERROR: begin
                err  = 1'b1;
                done = 1'b1;
                if (start) state_d = LOAD_A;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign iter_count  = cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: a behavioural A/B datapath closes the loop, a scoreboard checks each result.
`timescale 1ns/1ps
module tb_gcd_controller;
    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic gt, lt, eq, ldA, ldB, sel1, sel2, sel_in, busy, done, err;
    logic [W-1:0] iter_count;
    logic [2:0]   dbg_state;

    gcd_controller #(.CNT_W(W), .MAX_ITER(1000)) dut (
        .clk(clk), .rst(rst), .start(start),
        .gt(gt), .lt(lt), .eq(eq),
        .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
        .busy(busy), .done(done), .err(err),
        .iter_count(iter_count), .dbg_state_o(dbg_state)
    );

    // Narrow-counter instance with lt stuck high, used to observe saturation.
    logic       sat_start = 1'b0;
    logic       s_ldA, s_ldB, s_sel1, s_sel2, s_sel_in, s_busy, s_done, s_err;
    logic [3:0] s_iter;
    logic [2:0] s_state;

    gcd_controller #(.CNT_W(4), .MAX_ITER(1000)) sat_dut (
        .clk(clk), .rst(rst), .start(sat_start),
        .gt(1'b0), .lt(1'b1), .eq(1'b0),
        .ldA(s_ldA), .ldB(s_ldB), .sel1(s_sel1), .sel2(s_sel2), .sel_in(s_sel_in),
        .busy(s_busy), .done(s_done), .err(s_err),
        .iter_count(s_iter), .dbg_state_o(s_state)
    );

    // ---------------- behavioural datapath ----------------
    logic [W-1:0] a_q = '0, b_q = '0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic [W-1:0] data_in, mux1, mux2, diff;
    int sub_loads = 0;
    int opa_loads = 0;

    assign data_in = ldA ? op_a : op_b;
    assign mux1    = sel1 ? b_q : a_q;
    assign mux2    = sel2 ? b_q : a_q;
    assign diff    = mux1 - mux2;
    assign gt      = (a_q > b_q);
    assign lt      = (a_q < b_q);
    assign eq      = (a_q == b_q);

    always @(posedge clk) begin
        if (ldA) a_q <= sel_in ? data_in : diff;
        if (ldB) b_q <= sel_in ? data_in : diff;
        if ((ldA || ldB) && !sel_in) sub_loads <= sub_loads + 1;
        if (ldA && sel_in) opa_loads <= opa_loads + 1;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [W-1:0] g;
        logic [W-1:0] n;
        logic         e;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: Euclid by division. Subtractive GCD performs sum(quotients)-1 subtractions.
    function automatic exp_t ref_model(input int a, input int b);
        exp_t r;
        int x, y, t, qsum;
        x = a; y = b; qsum = 0;
        while (y != 0) begin
            qsum += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        r.g = W'(x);
        r.n = W'(qsum - 1);
        r.e = 1'b0;
        return r;
    endfunction

    task automatic push_run(input int a, input int b);
        op_a = W'(a);
        op_b = W'(b);
        exp_q.push_back(ref_model(a, b));
    endtask

    initial begin : monitor
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_err", 32'(err), 32'(e.e));
                    check("sb_iter", 32'(iter_count), 32'(e.n));
                    if (!e.e) begin
                        check("sb_gcd_a", 32'(a_q), 32'(e.g));
                        check("sb_gcd_b", 32'(b_q), 32'(e.g));
                    end
                end
            end
            done_prev = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: done=0 after %0d cycles, expected 1", name, budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_err"}, 32'(err), 32'(0));
        check({tag, "_iter"}, 32'(iter_count), 32'(0));
        check({tag, "_ld"}, 32'({ldA, ldB}), 32'(0));
        check({tag, "_sel"}, 32'({sel1, sel2}), 32'(0));
        check({tag, "_sel_in"}, 32'(sel_in), 32'(1));
        check({tag, "_state"}, 32'(dbg_state), 32'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int s0, l0;
        logic [W-1:0] a_snap, b_snap;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Counter saturation on the 4-bit instance.
        @(negedge clk) sat_start = 1'b1;
        @(negedge clk) sat_start = 1'b0;
        repeat (40) @(negedge clk);
        check("sat_iter", 32'(s_iter), 32'(15));
        check("sat_busy", 32'(s_busy), 32'(1));
        repeat (10) @(negedge clk);
        check("sat_iter_hold", 32'(s_iter), 32'(15));

        // 48,18: four subtractions, done on cycle 8 after start.
        push_run(48, 18);
        pulse_start();
        check("busy_after_start", 32'(busy), 32'(1));
        repeat (6) @(negedge clk);
        check("done_not_early", 32'(done), 32'(0));
        @(negedge clk);
        check("done_cycle8", 32'(done), 32'(1));
        check("iter_48_18", 32'(iter_count), 32'(4));
        check("a_48_18", 32'(a_q), 32'(6));

        // 7,7: eq immediately, no subtract loads.
        push_run(7, 7);
        s0 = sub_loads;
        pulse_start();
        wait_done("done_7_7", 50);
        check("iter_7_7", 32'(iter_count), 32'(0));
        check("subloads_7_7", 32'(sub_loads - s0), 32'(0));

        // Random operand pairs.
        for (int i = 0; i < 20; i++) begin
            push_run($urandom_range(1, 200), $urandom_range(1, 200));
            pulse_start();
            wait_done("done_rand", 600);
        end

        // 21,14 with start held through CALC: no restart, then a real restart.
        push_run(21, 14);
        l0 = opa_loads;
        @(negedge clk) start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("done_21_14", 32'(done), 32'(1));
        check("iter_21_14", 32'(iter_count), 32'(2));
        check("a_21_14", 32'(a_q), 32'(7));
        check("no_restart", 32'(opa_loads - l0), 32'(1));
        push_run(9, 6);
        pulse_start();
        wait_done("done_9_6", 50);
        check("reload_count", 32'(opa_loads - l0), 32'(2));
        check("a_reloaded", 32'(a_q), 32'(3));

        // Reset in the middle of CALC for 100,3.
        op_a = 16'd100;
        op_b = 16'd3;
        pulse_start();
        repeat (10) @(negedge clk);
        check("busy_mid_calc", 32'(busy), 32'(1));
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        a_snap = a_q;
        b_snap = b_q;
        s0 = sub_loads;
        repeat (2) @(negedge clk);
        check_reset_outputs("abort_held");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_a_hold", 32'(a_q), 32'(a_snap));
        check("abort_b_hold", 32'(b_q), 32'(b_snap));
        check("abort_no_loads", 32'(sub_loads - s0), 32'(0));
        check("abort_idle_busy", 32'(busy), 32'(0));
        check("abort_idle_done", 32'(done), 32'(0));

        // Zero operand: 0,5.
        op_a = 16'd0;
        op_b = 16'd5;
`ifdef GCD_ITER_LIMIT_EN
        exp_q.push_back('{g: '0, n: 16'd1000, e: 1'b1});
        pulse_start();
        wait_done("done_err", 1200);
        check("err_set", 32'(err), 32'(1));
        check("err_done", 32'(done), 32'(1));
        check("err_busy", 32'(busy), 32'(0));
        check("err_iter", 32'(iter_count), 32'(1000));
        push_run(12, 8);
        pulse_start();
        check("err_exit", 32'(err), 32'(0));
        wait_done("done_after_err", 50);
`else
        pulse_start();
        repeat (1100) @(negedge clk);
        check("noerr_err", 32'(err), 32'(0));
        check("noerr_busy", 32'(busy), 32'(1));
        check("noerr_iter", 32'(iter_count), 32'(1098));
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gcd_controller.md
GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the iteration counter.
REQ-002 The block SHALL have parameter MAX_ITER, default 1000, giving the subtraction-cycle limit (used only with GCD_ITER_LIMIT_EN).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request a new GCD computation.
REQ-006 The block SHALL have ports gt, lt and eq, inputs, 1 bit each: the datapath compare flags for A>B, A<B and A==B.
REQ-007 The block SHALL have ports ldA and ldB, outputs, 1 bit each: load enables for datapath registers A and B.
REQ-008 The block SHALL have port sel1, output, 1 bit: minuend select, 0=A and 1=B.
REQ-009 The block SHALL have port sel2, output, 1 bit: subtrahend select, 0=A and 1=B.
REQ-010 The block SHALL have port sel_in, output, 1 bit: bus source select, 1=data_in and 0=subtractor output.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a computation is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: high when the result is valid in A and B.
REQ-013 The block SHALL have port err, output, 1 bit: high when the iteration limit has been hit.
REQ-014 The block SHALL have port iter_count, output, CNT_W bits: the number of subtraction cycles in the current or last run.

Function
REQ-015 The block SHALL implement the states IDLE, LOAD_A, LOAD_B, CALC and DONE, plus ERROR when GCD_ITER_LIMIT_EN is defined.
REQ-016 In IDLE, the block SHALL drive ldA=ldB=0 and sel_in=1, and SHALL move to LOAD_A on start=1.
REQ-017 In LOAD_A, the block SHALL drive ldA=1 and sel_in=1 (the environment presents operand A on data_in this cycle), and SHALL then move to LOAD_B.
REQ-018 In LOAD_B, the block SHALL drive ldB=1 and sel_in=1 (operand B on data_in), clear iter_count to 0, and then move to CALC.
REQ-019 In CALC with eq=1, the block SHALL assert no load and move to DONE on the next edge.
REQ-020 In CALC with gt=1, the block SHALL drive ldA=1, sel1=0, sel2=1 and sel_in=0 (A<=A-B), increment iter_count, and stay in CALC.
REQ-021 In CALC with lt=1, the block SHALL drive ldB=1, sel1=1, sel2=0 and sel_in=0 (B<=B-A), increment iter_count, and stay in CALC.
REQ-022 In CALC, eq SHALL take priority over gt and lt, and gt SHALL take priority over lt if the flags are malformed.
REQ-023 Outputs ldA, ldB, sel1, sel2 and sel_in SHALL be combinational decodes of the current state and flags, with zero-cycle latency.
REQ-024 The block SHALL drive busy=1 in LOAD_A, LOAD_B and CALC, and busy=0 otherwise.
REQ-025 In DONE, the block SHALL hold done=1 with no loads, and SHALL go to LOAD_A when start=1 (restart), else stay in DONE.
REQ-026 The block SHALL ignore start while busy=1.
REQ-027 iter_count SHALL saturate at all-ones and never wrap.
REQ-028 iter_count SHALL hold its value in DONE and ERROR until the next LOAD_B.

Reset
REQ-029 On rst=1, the block SHALL immediately enter IDLE, regardless of clk.
REQ-030 While rst=1, the block SHALL drive busy=done=err=0, iter_count=0, ldA=ldB=0, sel1=sel2=0 and sel_in=1.
REQ-031 On rst=1 in any state, including mid-CALC, the block SHALL abort the computation, and no load SHALL occur on the next edge.

Configuration
REQ-032 The block SHALL support the macro GCD_ITER_LIMIT_EN.
REQ-033 With GCD_ITER_LIMIT_EN defined, the block SHALL move from CALC to ERROR, asserting no load, when iter_count==MAX_ITER and eq=0.
REQ-034 With GCD_ITER_LIMIT_EN defined, in ERROR the block SHALL drive err=1, done=1 and busy=0, and SHALL exit to LOAD_A on start=1.
REQ-035 Without GCD_ITER_LIMIT_EN, the block SHALL have no ERROR state, SHALL tie err to 0, and SHALL let CALC run unbounded (a zero operand never terminates).

Verification
REQ-036 The bench SHALL check: A=48, B=18, start pulse -> 4 CALC subtract cycles, then DONE; A=B=6, iter_count=4, done=1 on cycle 8 after start.
REQ-037 The bench SHALL check: A=7, B=7 -> CALC sees eq immediately; done=1 with iter_count=0 and no subtract loads.
REQ-038 The bench SHALL check, with the macro defined and MAX_ITER=1000: A=0, B=5 -> after 1000 subtract cycles err=1, done=1, busy=0; without the macro, err stays 0.
REQ-039 The bench SHALL check: rst pulsed during CALC of A=100, B=3 -> IDLE immediately, all outputs at reset values, no further loads.
REQ-040 The bench SHALL check: start held high during CALC of A=21, B=14 -> no restart; result 7 with iter_count=2, then a new start from DONE reloads the operands.
